// File: rtl/pixel_tap_sampler_if.sv
// pixel_tap_sampler_if: camera pixel stream feeding the tap sampler.
// frame_start/line_start are only meaningful while data_valid is high.
interface pixel_tap_sampler_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  frame_start;
  logic                  line_start;

  modport master (
    output data,
    output data_valid,
    output frame_start,
    output line_start
  );

  modport slave (
    input data,
    input data_valid,
    input frame_start,
    input line_start
  );
endinterface

// File: rtl/pixel_tap_sampler.sv
// pixel_tap_sampler: picks three tap pixels per frame, binarises them with
// hysteresis and flags missing taps. Option macro: TAP_MAJORITY_EN.
module pixel_tap_sampler #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned COLUMN_WIDTH   = 11,
  parameter int unsigned ROW_WIDTH      = 11,
  parameter int unsigned TAP0_COLUMN    = 63,
  parameter int unsigned TAP0_ROW       = 0,
  parameter int unsigned TAP1_COLUMN    = 511,
  parameter int unsigned TAP1_ROW       = 0,
  parameter int unsigned TAP2_COLUMN    = 1023,
  parameter int unsigned TAP2_ROW       = 0,
  parameter int unsigned THRESHOLD_HIGH = 160,
  parameter int unsigned THRESHOLD_LOW  = 96
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  pixel_tap_sampler_if.slave pix,
  output logic [2:0]         sample_data,
  output logic [2:0]         sample_strobe,
  output logic [15:0]        frame_count,
  output logic [2:0]         tap_missing
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    ACTIVE
  } state_e;

  localparam logic [COLUMN_WIDTH-1:0] COL_MAX = '1;
  localparam logic [ROW_WIDTH-1:0]    ROW_MAX = '1;
  localparam logic [DATA_WIDTH-1:0]   TH_HI   = DATA_WIDTH'(THRESHOLD_HIGH);
  localparam logic [DATA_WIDTH-1:0]   TH_LO   = DATA_WIDTH'(THRESHOLD_LOW);

  state_e state_q, state_d;

  logic [COLUMN_WIDTH-1:0] col_q, col_d;
  logic [ROW_WIDTH-1:0]    row_q, row_d;
  logic [2:0]              level_q, level_d;
  logic [2:0]              seen_q, seen_d;
  logic [2:0]              strobe_q, strobe_d;
  logic [2:0]              miss_q, miss_d;
  logic [15:0]             fcnt_q, fcnt_d;

`ifdef TAP_MAJORITY_EN
  logic [2:0][2:0]         hist_q, hist_d;
`endif

  logic [2:0][COLUMN_WIDTH-1:0] tap_col;
  logic [2:0][ROW_WIDTH-1:0]    tap_row;

  logic [COLUMN_WIDTH-1:0] pcol;
  logic [ROW_WIDTH-1:0]    prow;
  logic                    take;
  logic                    close;
  logic                    hi;
  logic                    lo;
  logic [2:0]              at_tap;
  logic [2:0]              seen_base;
  logic [2:0]              hit;
  logic [2:0]              lvl_new;

  assign tap_col = {
    COLUMN_WIDTH'(TAP2_COLUMN),
    COLUMN_WIDTH'(TAP1_COLUMN),
    COLUMN_WIDTH'(TAP0_COLUMN)
  };

  assign tap_row = {
    ROW_WIDTH'(TAP2_ROW),
    ROW_WIDTH'(TAP1_ROW),
    ROW_WIDTH'(TAP0_ROW)
  };

  // Coordinates of the current beat; both counters saturate.
  always_comb begin
    pcol = col_q;
    prow = row_q;
    priority case (1'b1)
      pix.frame_start: begin
        pcol = '0;
        prow = '0;
      end
      pix.line_start: begin
        pcol = '0;
        if (row_q != ROW_MAX) begin
          prow = row_q + ROW_WIDTH'(1);
        end
      end
      default: begin
        if (col_q != COL_MAX) begin
          pcol = col_q + COLUMN_WIDTH'(1);
        end
      end
    endcase
  end

  // Beat qualification and tap hits.
  always_comb begin
    take  = 1'b0;
    close = 1'b0;
    unique case (state_q)
      WAIT_FRAME: begin
        take = pix.data_valid & pix.frame_start;
      end
      ACTIVE: begin
        take  = pix.data_valid;
        close = pix.data_valid & pix.frame_start;
      end
      default: begin
        take = 1'b0;
      end
    endcase

    seen_base = pix.frame_start ? 3'b000 : seen_q;

    for (int n = 0; n < 3; n++) begin
      at_tap[n] = (pcol == tap_col[n]) && (prow == tap_row[n]);
    end

    hit = take ? (at_tap & ~seen_base) : 3'b000;

    hi = (pix.data >= TH_HI);
    lo = (pix.data <= TH_LO);
    for (int n = 0; n < 3; n++) begin
      lvl_new[n] = hi ? 1'b1 : (lo ? 1'b0 : level_q[n]);
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    level_d  = level_q;
    seen_d   = seen_q;
    strobe_d = 3'b000;
    fcnt_d   = fcnt_q;
    miss_d   = miss_q;
`ifdef TAP_MAJORITY_EN
    hist_d   = hist_q;
`endif

    if (clear) begin
      // State and coordinates survive; a coincident hit is dropped.
      fcnt_d  = '0;
      miss_d  = '0;
      level_d = '0;
      seen_d  = '0;
`ifdef TAP_MAJORITY_EN
      hist_d  = '0;
`endif
    end else if (!enable) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
      level_d = '0;
      seen_d  = '0;
`ifdef TAP_MAJORITY_EN
      hist_d  = '0;
`endif
    end else begin
      if (state_q == IDLE) begin
        state_d = WAIT_FRAME;
      end
      if (take) begin
        state_d  = ACTIVE;
        col_d    = pcol;
        row_d    = prow;
        seen_d   = seen_base | hit;
        strobe_d = hit;
        for (int n = 0; n < 3; n++) begin
          if (hit[n]) begin
            level_d[n] = lvl_new[n];
`ifdef TAP_MAJORITY_EN
            hist_d[n]  = {hist_q[n][1:0], lvl_new[n]};
`endif
          end
        end
        if (close) begin
          fcnt_d = fcnt_q + 16'd1;
          miss_d = miss_q | ~seen_q;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      level_q  <= '0;
      seen_q   <= '0;
      strobe_q <= '0;
      fcnt_q   <= '0;
      miss_q   <= '0;
`ifdef TAP_MAJORITY_EN
      hist_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      level_q  <= level_d;
      seen_q   <= seen_d;
      strobe_q <= strobe_d;
      fcnt_q   <= fcnt_d;
      miss_q   <= miss_d;
`ifdef TAP_MAJORITY_EN
      hist_q   <= hist_d;
`endif
    end
  end

`ifdef TAP_MAJORITY_EN
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      sample_data[n] = (hist_q[n][0] & hist_q[n][1])
                     | (hist_q[n][0] & hist_q[n][2])
                     | (hist_q[n][1] & hist_q[n][2]);
    end
  end
`else
  assign sample_data = level_q;
`endif

  assign sample_strobe = strobe_q;
  assign frame_count   = fcnt_q;
  assign tap_missing   = miss_q;

endmodule

// File: tb/tb_pixel_tap_sampler.sv
// tb_pixel_tap_sampler: directed frames with a strobe scoreboard.
// Tap1 is moved to (0,0) so frame-start beats exercise a tap hit.
`timescale 1ns/1ps
module tb_pixel_tap_sampler;

`ifdef TAP_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  sample_data;
  logic [2:0]  sample_strobe;
  logic [15:0] frame_count;
  logic [2:0]  tap_missing;

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  mask;
    logic [2:0]  bits;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t a;

  pixel_tap_sampler_if #(.DATA_WIDTH(8)) pif ();

  pixel_tap_sampler #(
    .TAP1_COLUMN(0),
    .TAP1_ROW(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .clear(clear),
    .pix(pif),
    .sample_data(sample_data),
    .sample_strobe(sample_strobe),
    .frame_count(frame_count),
    .tap_missing(tap_missing)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Monitor: every strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (q.size() > 0 && int'(q[0].cyc) < cyc) begin
      checks++;
      $display("FAIL strobe_missing: cycle %0d got none, required mask %b",
               q[0].cyc, q[0].mask);
      void'(q.pop_front());
    end
    if (sample_strobe != 3'b000) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL strobe_unexpected: cycle %0d strobe %b required none",
                 cyc, sample_strobe);
      end else begin
        e      = q.pop_front();
        a.cyc  = 32'(cyc);
        a.mask = sample_strobe;
        a.bits = sample_data & sample_strobe;
        chk("strobe", 64'(a), 64'(e));
      end
    end
  end

  task automatic beat(input logic dv, input logic fs, input logic ls,
                      input logic [7:0] d);
    @(negedge clock);
    pif.data_valid  = dv;
    pif.frame_start = fs;
    pif.line_start  = ls;
    pif.data        = d;
  endtask

  task automatic expect_hit(input logic [2:0] mask, input logic bitv);
    exp_t x;
    x.cyc  = 32'(cyc + 1);
    x.mask = mask;
    x.bits = bitv ? mask : 3'b000;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic frame(input int ncols, input int nrows, input logic fsls,
                       input logic [7:0] t0, input logic e0);
    logic [7:0] d;
    for (int c = 0; c < ncols; c++) begin
      if (c % 200 == 199) beat(1'b0, 1'b1, 1'b1, 8'hff);
      d = (c == 63) ? t0 : ((c == 1023) ? 8'd0 : 8'(c));
      beat(1'b1, c == 0, fsls && (c == 0), d);
      if (c == 0)    expect_hit(3'b010, 1'b0);
      if (c == 63)   expect_hit(3'b001, e0);
      if (c == 1023) expect_hit(3'b100, 1'b0);
    end
    for (int r = 1; r < nrows; r++) begin
      for (int c = 0; c < 70; c++) beat(1'b1, 1'b0, c == 0, 8'd200);
    end
  endtask

  initial begin
    pif.data        = '0;
    pif.data_valid  = 1'b0;
    pif.frame_start = 1'b0;
    pif.line_start  = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_sample", 64'(sample_data), 64'(0));
    chk("rst_strobe", 64'(sample_strobe), 64'(0));
    chk("rst_count", 64'(frame_count), 64'(0));
    chk("rst_missing", 64'(tap_missing), 64'(0));

    reset  = 1'b0;
    enable = 1'b1;
    idle(2);

    frame(70, 1, 1'b0, 8'd200, ~MAJ);
    frame(70, 1, 1'b0, 8'd200, 1'b1);
    idle(2);
    chk("pre_count", 64'(frame_count), 64'(1));
    chk("pre_missing", 64'(tap_missing), 64'(3'b100));
    chk("pre_sample", 64'(sample_data), 64'(3'b001));

    reset = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 8'd200);
    beat(1'b1, 1'b0, 1'b0, 8'd200);
    reset = 1'b0;
    chk("midrst_sample", 64'(sample_data), 64'(0));
    chk("midrst_strobe", 64'(sample_strobe), 64'(0));
    chk("midrst_count", 64'(frame_count), 64'(0));
    chk("midrst_missing", 64'(tap_missing), 64'(0));
    idle(2);

    frame(1024, 2, 1'b0, 8'd200, ~MAJ);
    frame(1024, 2, 1'b0, 8'd120, 1'b1);
    frame(1024, 2, 1'b0, 8'd50, MAJ);
    frame(1024, 2, 1'b0, 8'd200, 1'b1);
    idle(2);
    chk("full_count", 64'(frame_count), 64'(3));
    chk("full_missing", 64'(tap_missing), 64'(0));
    chk("full_sample", 64'(sample_data), 64'(3'b001));

    frame(600, 1, 1'b0, 8'd200, 1'b1);
    beat(1'b1, 1'b1, 1'b0, 8'd0);
    expect_hit(3'b010, 1'b0);
    idle(2);
    chk("short_count", 64'(frame_count), 64'(5));
    chk("short_missing", 64'(tap_missing), 64'(3'b100));

    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clr_count", 64'(frame_count), 64'(0));
    chk("clr_missing", 64'(tap_missing), 64'(0));
    chk("clr_sample", 64'(sample_data), 64'(0));

    for (int c = 1; c <= 70; c++) begin
      beat(1'b1, 1'b0, 1'b0, (c == 63) ? 8'd200 : 8'(c));
      if (c == 63) expect_hit(3'b001, ~MAJ);
    end
    idle(2);
    chk("resume_sample", 64'(sample_data), 64'({2'b00, ~MAJ}));

    enable = 1'b0;
    idle(1);
    chk("dis_sample", 64'(sample_data), 64'(0));
    chk("dis_count", 64'(frame_count), 64'(0));
    enable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      beat(1'b1, 1'b0, c == 50, (c % 2 == 1) ? 8'd200 : 8'd0);
    end

    frame(100, 1, 1'b1, 8'd160, ~MAJ);
    frame(70, 1, 1'b1, 8'd97, 1'b1);
    frame(70, 1, 1'b0, 8'd96, MAJ);
    frame(70, 1, 1'b0, 8'd159, 1'b0);
    idle(2);
    chk("fsls_count", 64'(frame_count), 64'(3));
    chk("fsls_missing", 64'(tap_missing), 64'(3'b100));

    beat(1'b1, 1'b1, 1'b1, 8'd0);
    expect_hit(3'b010, 1'b0);
    idle(3);
    chk("end_count", 64'(frame_count), 64'(4));
    chk("end_missing", 64'(tap_missing), 64'(3'b100));

    idle(4);
    chk("sb_drained", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: cycle %0d reached, required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
